// File: rtl/vy_blok_donusturucu.sv
// vy_blok_donusturucu: turns one cache block read/write into a sequence of
// single-word beats on the memory port. One beat is outstanding at a time.
module vy_blok_donusturucu #(
  parameter int unsigned ADRES_BIT       = 32,
  parameter int unsigned BLOK_BIT        = 128,
  parameter int unsigned BELLEK_VERI_BIT = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  // upstream block request
  input  logic [ADRES_BIT-1:0]       vy_istek_adres_i,
  input  logic                       vy_istek_gecerli_i,
  output logic                       vy_istek_hazir_o,
  input  logic                       vy_istek_yaz_i,
  input  logic [BLOK_BIT-1:0]        vy_istek_veri_i,
  // upstream read response
  output logic [BLOK_BIT-1:0]        vy_veri_o,
  output logic                       vy_veri_gecerli_o,
  input  logic                       vy_veri_hazir_i,
  // memory beat request
  output logic [ADRES_BIT-1:0]       bellek_istek_adres_o,
  output logic                       bellek_istek_gecerli_o,
  input  logic                       bellek_istek_hazir_i,
  output logic                       bellek_istek_yaz_o,
  output logic [BELLEK_VERI_BIT-1:0] bellek_istek_veri_o,
  // memory read beat
  input  logic [BELLEK_VERI_BIT-1:0] bellek_veri_i,
  input  logic                       bellek_veri_gecerli_i,
  output logic                       bellek_veri_hazir_o
);

  localparam int unsigned BEAT      = BLOK_BIT / BELLEK_VERI_BIT;
  localparam int unsigned SAYAC_BIT = (BEAT > 1) ? $clog2(BEAT) : 1;
  localparam int unsigned BEAT_BAYT = BELLEK_VERI_BIT / 8;
  localparam int unsigned BLOK_OFS  = $clog2(BLOK_BIT / 8);
  localparam int unsigned DILIM_BIT = (BLOK_BIT > 1) ? $clog2(BLOK_BIT) : 1;

  localparam logic [ADRES_BIT-1:0] TABAN_MASKE =
    ~((ADRES_BIT'(1) << BLOK_OFS) - ADRES_BIT'(1));
  localparam logic [SAYAC_BIT-1:0] SON_BEAT = SAYAC_BIT'(BEAT - 1);

  localparam logic [2:0] BOSTA     = 3'd0;
  localparam logic [2:0] OKU_ISTEK = 3'd1;
  localparam logic [2:0] OKU_BEKLE = 3'd2;
  localparam logic [2:0] YANIT     = 3'd3;
  localparam logic [2:0] YAZ_ISTEK = 3'd4;

  logic [2:0]                 durum_q, durum_d;
  logic [SAYAC_BIT-1:0]       sayac_q, sayac_d;
  logic [ADRES_BIT-1:0]       taban_q, taban_d;
  logic [BLOK_BIT-1:0]        yaz_blok_q, yaz_blok_d;

  logic [ADRES_BIT-1:0]       adres_d;
  logic                       istek_gecerli_d;
  logic                       istek_yaz_d;
  logic [BELLEK_VERI_BIT-1:0] istek_veri_d;
  logic                       veri_hazir_d;
  logic [BLOK_BIT-1:0]        vy_veri_d;
  logic                       vy_gecerli_d;

  logic                       beat_ilerle;
  logic [DILIM_BIT-1:0]       oku_dilim;
  logic [DILIM_BIT-1:0]       yaz_dilim;

  // Upstream may hand over a new block only while idle.
  assign vy_istek_hazir_o = (durum_q == BOSTA);

  // Next-state and next-output logic; every registered value holds by default.
  always_comb begin
    durum_d         = durum_q;
    sayac_d         = sayac_q;
    taban_d         = taban_q;
    yaz_blok_d      = yaz_blok_q;
    adres_d         = bellek_istek_adres_o;
    istek_gecerli_d = bellek_istek_gecerli_o;
    istek_yaz_d     = bellek_istek_yaz_o;
    istek_veri_d    = bellek_istek_veri_o;
    veri_hazir_d    = bellek_veri_hazir_o;
    vy_veri_d       = vy_veri_o;
    vy_gecerli_d    = vy_veri_gecerli_o;
    beat_ilerle     = 1'b0;
    oku_dilim       = DILIM_BIT'(int'(sayac_q) * int'(BELLEK_VERI_BIT));
    yaz_dilim       = '0;

    case (durum_q)
      BOSTA: begin
        if (vy_istek_gecerli_i) begin
          taban_d         = vy_istek_adres_i & TABAN_MASKE;
          yaz_blok_d      = vy_istek_veri_i;
          sayac_d         = '0;
          adres_d         = vy_istek_adres_i & TABAN_MASKE;
          istek_gecerli_d = 1'b1;
          istek_yaz_d     = vy_istek_yaz_i;
          istek_veri_d    = vy_istek_veri_i[BELLEK_VERI_BIT-1:0];
          durum_d         = vy_istek_yaz_i ? YAZ_ISTEK : OKU_ISTEK;
        end
      end
      OKU_ISTEK: begin
        if (bellek_istek_gecerli_o && bellek_istek_hazir_i) begin
          istek_gecerli_d = 1'b0;
          veri_hazir_d    = 1'b1;
          durum_d         = OKU_BEKLE;
        end
      end
      OKU_BEKLE: begin
        if (bellek_veri_gecerli_i && bellek_veri_hazir_o) begin
          vy_veri_d[oku_dilim +: BELLEK_VERI_BIT] = bellek_veri_i;
          veri_hazir_d = 1'b0;
          if (sayac_q == SON_BEAT) begin
            vy_gecerli_d = 1'b1;
            durum_d      = YANIT;
          end else begin
            sayac_d         = sayac_q + SAYAC_BIT'(1);
            beat_ilerle     = 1'b1;
            istek_gecerli_d = 1'b1;
            durum_d         = OKU_ISTEK;
          end
        end
      end
      YANIT: begin
        if (vy_veri_hazir_i) begin
          vy_gecerli_d = 1'b0;
          durum_d      = BOSTA;
        end
      end
      YAZ_ISTEK: begin
        if (bellek_istek_gecerli_o && bellek_istek_hazir_i) begin
          if (sayac_q == SON_BEAT) begin
            istek_gecerli_d = 1'b0;
            durum_d         = BOSTA;
          end else begin
            sayac_d     = sayac_q + SAYAC_BIT'(1);
            beat_ilerle = 1'b1;
          end
        end
      end
      default: begin
        durum_d = BOSTA;
      end
    endcase

    // Moving to the next beat: recompute its address and write slice.
    if (beat_ilerle) begin
      yaz_dilim    = DILIM_BIT'(int'(sayac_d) * int'(BELLEK_VERI_BIT));
      adres_d      = taban_q + ADRES_BIT'(sayac_d) * ADRES_BIT'(BEAT_BAYT);
      istek_veri_d = yaz_blok_q[yaz_dilim +: BELLEK_VERI_BIT];
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      durum_q                <= BOSTA;
      sayac_q                <= '0;
      taban_q                <= '0;
      yaz_blok_q             <= '0;
      bellek_istek_adres_o   <= '0;
      bellek_istek_gecerli_o <= 1'b0;
      bellek_istek_yaz_o     <= 1'b0;
      bellek_istek_veri_o    <= '0;
      bellek_veri_hazir_o    <= 1'b0;
      vy_veri_o              <= '0;
      vy_veri_gecerli_o      <= 1'b0;
    end else begin
      durum_q                <= durum_d;
      sayac_q                <= sayac_d;
      taban_q                <= taban_d;
      yaz_blok_q             <= yaz_blok_d;
      bellek_istek_adres_o   <= adres_d;
      bellek_istek_gecerli_o <= istek_gecerli_d;
      bellek_istek_yaz_o     <= istek_yaz_d;
      bellek_istek_veri_o    <= istek_veri_d;
      bellek_veri_hazir_o    <= veri_hazir_d;
      vy_veri_o              <= vy_veri_d;
      vy_veri_gecerli_o      <= vy_gecerli_d;
    end
  end

endmodule

// File: tb/tb_vy_blok_donusturucu.sv
// Bench for vy_blok_donusturucu: transaction-level model plus a memory
// responder; every cycle the DUT outputs are compared with the model.
module tb_vy_blok_donusturucu;

  localparam int BEAT = 4;

  logic         clk;
  logic         rst_i;
  logic [31:0]  vy_istek_adres_i;
  logic         vy_istek_gecerli_i;
  logic         vy_istek_hazir_o;
  logic         vy_istek_yaz_i;
  logic [127:0] vy_istek_veri_i;
  logic [127:0] vy_veri_o;
  logic         vy_veri_gecerli_o;
  logic         vy_veri_hazir_i;
  logic [31:0]  bellek_istek_adres_o;
  logic         bellek_istek_gecerli_o;
  logic         bellek_istek_hazir_i;
  logic         bellek_istek_yaz_o;
  logic [31:0]  bellek_istek_veri_o;
  logic [31:0]  bellek_veri_i;
  logic         bellek_veri_gecerli_i;
  logic         bellek_veri_hazir_o;

  vy_blok_donusturucu dut (
    .clk_i                  (clk),
    .rst_i                  (rst_i),
    .vy_istek_adres_i       (vy_istek_adres_i),
    .vy_istek_gecerli_i     (vy_istek_gecerli_i),
    .vy_istek_hazir_o       (vy_istek_hazir_o),
    .vy_istek_yaz_i         (vy_istek_yaz_i),
    .vy_istek_veri_i        (vy_istek_veri_i),
    .vy_veri_o              (vy_veri_o),
    .vy_veri_gecerli_o      (vy_veri_gecerli_o),
    .vy_veri_hazir_i        (vy_veri_hazir_i),
    .bellek_istek_adres_o   (bellek_istek_adres_o),
    .bellek_istek_gecerli_o (bellek_istek_gecerli_o),
    .bellek_istek_hazir_i   (bellek_istek_hazir_i),
    .bellek_istek_yaz_o     (bellek_istek_yaz_o),
    .bellek_istek_veri_o    (bellek_istek_veri_o),
    .bellek_veri_i          (bellek_veri_i),
    .bellek_veri_gecerli_i  (bellek_veri_gecerli_i),
    .bellek_veri_hazir_o    (bellek_veri_hazir_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [31:0] a;
    logic        y;
    logic [31:0] d;
  } beat_t;

  int checks = 0;
  int errors = 0;

  // transaction model
  bit           izle = 1'b0;
  bit           m_mesgul = 1'b0;
  bit           m_yaz = 1'b0;
  bit           m_bekleyen = 1'b0;
  logic [31:0]  m_taban = '0;
  logic [31:0]  m_bek_adres = '0;
  logic [127:0] m_blok = '0;
  int           m_verilen = 0;
  int           m_donen = 0;
  logic [31:0]  mem_tbl [logic [31:0]];
  beat_t        beat_log [$];
  logic [127:0] son_blok = '0;
  int           cyc = 0;
  int           kabul_sayac = 0;
  int           son_kabul_cyc = 0;
  int           son_yanit_cyc = 0;
  int           beat2_durma = 0;
  int           yanit_durma = 0;
  int           son_yanit_durma = 0;
  bit           e_gec, e_vy;
  logic [31:0]  e_adr;

  // stimulus controls
  bit hizli = 1'b0;
  bit durdur_aktif = 1'b0;
  bit yanit_tut = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (mem_tbl.exists(a)) return mem_tbl[a];
    return {a[15:0], ~a[31:16]} ^ 32'h5A3C_96E1;
  endfunction

  task automatic chk(input string ad, input logic [127:0] g, input logic [127:0] b);
    checks++;
    if (g !== b) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", ad, g, b, $time);
    end
  endtask

  // per-cycle compare and model update, sampled mid-cycle
  initial forever begin
    @(negedge clk);
    if (izle) begin
      cyc++;
      e_gec = m_mesgul && (m_verilen < BEAT) && !m_bekleyen;
      e_vy  = m_mesgul && !m_yaz && (m_donen == BEAT);
      e_adr = m_taban + 32'(m_verilen) * 32'd4;
      chk("vy_istek_hazir", 128'(vy_istek_hazir_o), 128'(!m_mesgul));
      chk("bellek_istek_gecerli", 128'(bellek_istek_gecerli_o), 128'(e_gec));
      chk("bellek_veri_hazir", 128'(bellek_veri_hazir_o), 128'(m_bekleyen));
      chk("vy_veri_gecerli", 128'(vy_veri_gecerli_o), 128'(e_vy));
      if (e_gec) begin
        chk("beat_adres", 128'(bellek_istek_adres_o), 128'(e_adr));
        chk("beat_yaz", 128'(bellek_istek_yaz_o), 128'(m_yaz));
        if (m_yaz)
          chk("beat_veri", 128'(bellek_istek_veri_o), 128'(m_blok[m_verilen*32 +: 32]));
      end
      if (e_vy) chk("vy_veri", vy_veri_o, m_blok);
      if (bellek_istek_gecerli_o && !bellek_istek_hazir_i &&
          bellek_istek_adres_o == m_taban + 32'd8)
        beat2_durma++;
      if (e_vy && !vy_veri_hazir_i) yanit_durma++;

      if (rst_i) begin
        m_mesgul = 1'b0; m_bekleyen = 1'b0; m_verilen = 0; m_donen = 0;
      end else if (!m_mesgul) begin
        if (vy_istek_gecerli_i) begin
          m_mesgul = 1'b1;
          m_yaz = vy_istek_yaz_i;
          m_taban = vy_istek_adres_i & ~32'hF;
          m_verilen = 0; m_donen = 0; m_bekleyen = 1'b0;
          if (vy_istek_yaz_i) m_blok = vy_istek_veri_i;
          else for (int k = 0; k < BEAT; k++)
            m_blok[k*32 +: 32] = mem_word(m_taban + 32'(k) * 32'd4);
          kabul_sayac++;
          son_kabul_cyc = cyc;
          beat2_durma = 0;
          yanit_durma = 0;
        end
      end else begin
        if (e_gec && bellek_istek_hazir_i) begin
          beat_log.push_back('{a: bellek_istek_adres_o, y: bellek_istek_yaz_o, d: bellek_istek_veri_o});
          if (m_yaz) mem_tbl[e_adr] = m_blok[m_verilen*32 +: 32];
          else begin m_bekleyen = 1'b1; m_bek_adres = e_adr; end
          m_verilen++;
          if (m_yaz && m_verilen == BEAT) m_mesgul = 1'b0;
        end else if (m_bekleyen && bellek_veri_gecerli_i) begin
          m_bekleyen = 1'b0;
          m_donen++;
        end else if (e_vy && vy_veri_hazir_i) begin
          son_blok = vy_veri_o;
          son_yanit_cyc = cyc;
          son_yanit_durma = yanit_durma;
          m_mesgul = 1'b0;
        end
      end
    end
  end

  // memory responder and upstream read-ready driver
  int gec_say = 0;
  bit gorulen = 1'b0;
  int durdur_say = 0;
  int yanit_say = 0;
  initial forever begin
    @(posedge clk);
    #1;
    if (!durdur_aktif) durdur_say = 0;
    if (!yanit_tut) yanit_say = 0;
    if (durdur_aktif) begin
      if (m_mesgul && m_verilen == 2 && !m_bekleyen && durdur_say < 5) begin
        bellek_istek_hazir_i = 1'b0;
        durdur_say++;
      end else bellek_istek_hazir_i = 1'b1;
    end else if (hizli) bellek_istek_hazir_i = 1'b1;
    else bellek_istek_hazir_i = ($urandom_range(0, 3) != 0);

    if (m_bekleyen) begin
      if (!gorulen) begin
        gorulen = 1'b1;
        gec_say = hizli ? 0 : int'($urandom_range(0, 3));
      end
      if (gec_say == 0) begin
        bellek_veri_gecerli_i = 1'b1;
        bellek_veri_i = mem_word(m_bek_adres);
      end else begin
        gec_say--;
        bellek_veri_gecerli_i = 1'b0;
        bellek_veri_i = $urandom;
      end
    end else begin
      gorulen = 1'b0;
      bellek_veri_gecerli_i = ($urandom_range(0, 2) == 0);
      bellek_veri_i = $urandom;
    end

    if (yanit_tut) begin
      if (m_mesgul && !m_yaz && m_donen == BEAT && yanit_say < 3) begin
        vy_veri_hazir_i = 1'b0;
        yanit_say++;
      end else vy_veri_hazir_i = 1'b1;
    end else vy_veri_hazir_i = ($urandom_range(0, 2) != 0);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic istek(input logic [31:0] a, input bit y, input logic [127:0] d);
    int k0;
    bit ok;
    k0 = kabul_sayac;
    ok = 1'b0;
    @(posedge clk); #1;
    vy_istek_gecerli_i = 1'b1;
    vy_istek_adres_i = a;
    vy_istek_yaz_i = y;
    vy_istek_veri_i = d;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      if (kabul_sayac != k0) begin ok = 1'b1; break; end
    end
    vy_istek_gecerli_i = 1'b0;
    vy_istek_veri_i = '0;
    if (!ok) chk("istek_kabul_zaman", 128'(0), 128'(1));
  endtask

  task automatic bos_bekle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk); #1;
      if (!m_mesgul) begin ok = 1'b1; break; end
    end
    if (!ok) chk("bos_bekle_zaman", 128'(0), 128'(1));
  endtask

  int bas;
  bit ok;
  logic [31:0] ra;

  initial begin
    rst_i = 1'b1;
    vy_istek_adres_i = '0; vy_istek_gecerli_i = 1'b0; vy_istek_yaz_i = 1'b0;
    vy_istek_veri_i = '0; vy_veri_hazir_i = 1'b0;
    bellek_istek_hazir_i = 1'b0; bellek_veri_i = '0; bellek_veri_gecerli_i = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;
    izle = 1'b1;

    // reset state
    @(negedge clk); #1;
    chk("rst_istek_hazir", 128'(vy_istek_hazir_o), 128'(1));
    chk("rst_bellek_gecerli", 128'(bellek_istek_gecerli_o), 128'(0));
    chk("rst_vy_gecerli", 128'(vy_veri_gecerli_o), 128'(0));
    chk("rst_vy_veri", vy_veri_o, 128'(0));
    chk("rst_adres", 128'(bellek_istek_adres_o), 128'(0));

    // block write then read of 0x1234 with an always-ready memory
    hizli = 1'b1;
    istek(32'h0000_1230, 1'b1, 128'h44444444_33333333_22222222_11111111);
    bos_bekle();
    bas = beat_log.size();
    istek(32'h0000_1234, 1'b0, 128'h0);
    bos_bekle();
    chk("oku_adres0", 128'(beat_log[bas].a), 128'(32'h1230));
    chk("oku_adres1", 128'(beat_log[bas+1].a), 128'(32'h1234));
    chk("oku_adres2", 128'(beat_log[bas+2].a), 128'(32'h1238));
    chk("oku_adres3", 128'(beat_log[bas+3].a), 128'(32'h123C));
    chk("oku_blok", son_blok, 128'h44444444_33333333_22222222_11111111);
    hizli = 1'b0;

    // write of 0x2000: first beat data, re-ready right after last handshake
    bas = beat_log.size();
    istek(32'h0000_2000, 1'b1, 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA);
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk); #1;
      if (beat_log.size() >= bas + 4) begin ok = 1'b1; break; end
    end
    if (!ok) chk("yaz_beat_zaman", 128'(0), 128'(1));
    chk("yaz_son_hazir_once", 128'(vy_istek_hazir_o), 128'(0));
    @(negedge clk); #1;
    chk("yaz_son_hazir_sonra", 128'(vy_istek_hazir_o), 128'(1));
    chk("yaz_adres0", 128'(beat_log[bas].a), 128'(32'h2000));
    chk("yaz_veri0", 128'(beat_log[bas].d), 128'(32'hAAAAAAAA));
    chk("yaz_yaz0", 128'(beat_log[bas].y), 128'(1));
    chk("yaz_veri3", 128'(beat_log[bas+3].d), 128'(32'hDDDDDDDD));

    // memory stalls beat 2 for five cycles
    durdur_aktif = 1'b1;
    bas = beat_log.size();
    istek(32'h0000_3004, 1'b1, {$urandom, $urandom, $urandom, $urandom});
    bos_bekle();
    durdur_aktif = 1'b0;
    chk("beat2_durma", 128'(beat2_durma), 128'(5));
    chk("durma_adres2", 128'(beat_log[bas+2].a), 128'(32'h3008));
    chk("durma_adres3", 128'(beat_log[bas+3].a), 128'(32'h300C));

    // pending request while the read block waits three cycles for ready
    yanit_tut = 1'b1;
    istek(32'h0000_4010, 1'b0, 128'h0);
    istek(32'h0000_5020, 1'b0, 128'h0);
    chk("yanit_durma", 128'(son_yanit_durma), 128'(3));
    chk("kabul_gecikme", 128'(son_kabul_cyc - son_yanit_cyc), 128'(1));
    bos_bekle();
    yanit_tut = 1'b0;

    // reset in the middle of a read burst
    istek(32'h0000_7770, 1'b0, 128'h0);
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk); #1;
      if (m_verilen == 2) begin ok = 1'b1; break; end
    end
    if (!ok) chk("beat2_zaman", 128'(0), 128'(1));
    @(posedge clk); #1 rst_i = 1'b1;
    @(posedge clk); #1 rst_i = 1'b0;
    @(negedge clk); #1;
    chk("rst_orta_vy_veri", vy_veri_o, 128'(0));
    chk("rst_orta_adres", 128'(bellek_istek_adres_o), 128'(0));
    chk("rst_orta_gecerli", 128'(bellek_istek_gecerli_o), 128'(0));
    chk("rst_orta_hazir", 128'(vy_istek_hazir_o), 128'(1));
    bas = beat_log.size();
    istek(32'h0000_6008, 1'b0, 128'h0);
    bos_bekle();
    chk("rst_sonra_adres0", 128'(beat_log[bas].a), 128'(32'h6000));

    // random traffic
    for (int n = 0; n < 80; n++) begin
      ra = $urandom;
      istek(ra, 1'($urandom_range(0, 1)), {$urandom, $urandom, $urandom, $urandom});
      if ($urandom_range(0, 1) == 0) bos_bekle();
    end
    bos_bekle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vy_blok_donusturucu.md
VY_BLOK_DONUSTURUCU -- requirements
Module: vy_blok_donusturucu

Purpose: sits directly downstream of the L1 data cache controller's bus port. It turns one block read or write into a sequence of word beats on the memory port.

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high.
REQ-002 Parameter ADRES_BIT, default 32: byte address width.
REQ-003 Parameter BLOK_BIT, default 128: cache block width.
REQ-004 Parameter BELLEK_VERI_BIT, default 32: memory beat width; BLOK_BIT SHALL be an integer multiple of it; BEAT = BLOK_BIT/BELLEK_VERI_BIT (default 4).
REQ-005 clk_i  in  1  clock.
REQ-006 rst_i  in  1  synchronous active-high reset.
REQ-007 vy_istek_adres_i  in  ADRES_BIT  block request address.
REQ-008 vy_istek_gecerli_i  in  1  upstream request valid.
REQ-009 vy_istek_hazir_o  out  1  request accepted when valid and ready are both high.
REQ-010 vy_istek_yaz_i  in  1  1 = block write, 0 = block read.
REQ-011 vy_istek_veri_i  in  BLOK_BIT  write block.
REQ-012 vy_veri_o  out  BLOK_BIT  assembled read block.
REQ-013 vy_veri_gecerli_o  out  1  read block valid.
REQ-014 vy_veri_hazir_i  in  1  upstream ready to take the read block.
REQ-015 bellek_istek_adres_o  out  ADRES_BIT  beat address.
REQ-016 bellek_istek_gecerli_o  out  1  beat request valid.
REQ-017 bellek_istek_hazir_i  in  1  memory accepts the beat request.
REQ-018 bellek_istek_yaz_o  out  1  beat is a write.
REQ-019 bellek_istek_veri_o  out  BELLEK_VERI_BIT  write beat data.
REQ-020 bellek_veri_i  in  BELLEK_VERI_BIT  read beat data.
REQ-021 bellek_veri_gecerli_i  in  1  read beat valid.
REQ-022 bellek_veri_hazir_o  out  1  ready for a read beat.

Function
REQ-023 States SHALL be BOSTA, OKU_ISTEK, OKU_BEKLE, YANIT and YAZ_ISTEK; the beat counter SHALL be clog2(BEAT) bits wide.
REQ-024 vy_istek_hazir_o SHALL be high only in BOSTA (combinational).
REQ-025 On acceptance, the block SHALL latch base = address with the low clog2(BLOK_BIT/8) bits cleared, latch the write data and set the counter to 0.
REQ-026 On acceptance the next state SHALL be YAZ_ISTEK for a write and OKU_ISTEK for a read.
REQ-027 Beat k SHALL use address base + k*(BELLEK_VERI_BIT/8) and block slice [k*BELLEK_VERI_BIT +: BELLEK_VERI_BIT] (little-endian).
REQ-028 All bellek_* outputs, vy_veri_o and vy_veri_gecerli_o SHALL be registered.
REQ-029 bellek_istek_gecerli_o SHALL rise in the cycle after acceptance.
REQ-030 OKU_ISTEK: present read beat k; on bellek_istek_gecerli_o && bellek_istek_hazir_i, drop valid, raise bellek_veri_hazir_o and go to OKU_BEKLE.
REQ-031 OKU_BEKLE: on bellek_veri_gecerli_i && bellek_veri_hazir_o, store the data in slice k and drop hazir.
REQ-032 OKU_BEKLE exit: if k == BEAT-1, go to YANIT with vy_veri_gecerli_o high the next cycle; otherwise increment k and return to OKU_ISTEK with valid high the next cycle.
REQ-033 Only one read beat SHALL be outstanding at any time.
REQ-034 YANIT: vy_veri_o and vy_veri_gecerli_o SHALL hold stable until vy_veri_hazir_i; on that handshake, drop valid and go to BOSTA.
REQ-035 YAZ_ISTEK: present write beat k with bellek_istek_yaz_o = 1; on handshake, if k == BEAT-1 go to BOSTA with valid low, else increment k and keep valid high.
REQ-036 A write SHALL produce no upstream response.
REQ-037 While bellek_istek_hazir_i is low, address, data, yaz and valid SHALL hold stable.
REQ-038 bellek_veri_gecerli_i SHALL be ignored outside OKU_BEKLE (bellek_veri_hazir_o low).
REQ-039 Upstream requests outside BOSTA SHALL not be accepted.
REQ-040 The counter SHALL never exceed BEAT-1 and SHALL be reset to 0 on acceptance.

Reset
REQ-041 While rst_i is high at a clock edge, the state SHALL become BOSTA, all valid/hazir outputs 0, the counter 0, and the address/data registers and vy_veri_o 0.
REQ-042 Reset asserted mid-burst SHALL abandon the burst with no further beats issued; the next accepted request SHALL start at beat 0.

Verification
REQ-043 Read of 0x0000_1234, memory ready immediately, beat data 0x11111111..0x44444444 -> beat addresses 0x1230, 0x1234, 0x1238, 0x123C; vy_veri_o = 0x44444444_33333333_22222222_11111111, valid held until vy_veri_hazir_i.
REQ-044 Write of 0x0000_2000 with block 0xDDDD..._AAAAAAAA -> four write beats, first data 0xAAAAAAAA at 0x2000; vy_istek_hazir_o high again in the cycle after the 4th handshake.
REQ-045 bellek_istek_hazir_i held low for 5 cycles on beat 2 -> outputs stable for all 5 cycles, then beat 3 follows.
REQ-046 Spurious bellek_veri_gecerli_i in BOSTA and YAZ_ISTEK -> ignored, no state change.
REQ-047 rst_i asserted during read beat 2 -> next cycle all valids 0 and state BOSTA; a new read starts at beat 0 with correct data.
REQ-048 vy_veri_hazir_i low for 3 cycles in YANIT with a new vy_istek_gecerli_i pending -> request not accepted until the cycle after the block handshake.
